// File: rtl/ucsbece154b_pred_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154b_pred_pkg
// Brief    : Shared types for the gshare branch predictor. Holds the 2-bit
//            counter encodings, the PHT reset value, the BTB entry layout and
//            the saturating counter update helper.
// Revision : 1.0 - initial release
// ============================================================================
package ucsbece154b_pred_pkg;

  // 2-bit saturating counter encodings
  localparam logic [1:0] SNT       = 2'b00;  // strongly not taken
  localparam logic [1:0] WNT       = 2'b01;  // weakly not taken
  localparam logic [1:0] WT        = 2'b10;  // weakly taken
  localparam logic [1:0] ST        = 2'b11;  // strongly taken
  localparam logic [1:0] PHT_RESET = WNT;

  // One BTB slot: jump marks unconditional control flow (jal/jalr)
  typedef struct packed {
    logic        valid;
    logic        jump;
    logic [31:0] target;
  } btb_entry_t;

  // Move a counter one step toward taken or not-taken, clamped at the ends
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic inc);
    logic [1:0] w_next;
    w_next = ctr;
    if (inc) begin
      if (ctr != ST) w_next = ctr + 2'b01;
    end else begin
      if (ctr != SNT) w_next = ctr - 2'b01;
    end
    return w_next;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucsbece154b_pht.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154b_pht
// Brief    : Pattern history table of 2-bit saturating counters. One
//            combinational read port, one clocked update port.
// Revision : 1.0 - initial release
// ============================================================================
module ucsbece154b_pht
  import ucsbece154b_pred_pkg::*;
#(
  parameter int NUM_GHR_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [NUM_GHR_BITS-1:0] i_raddr,
  output logic [1:0]              o_rdata,
  input  logic                    i_we,
  input  logic                    i_inc,
  input  logic [NUM_GHR_BITS-1:0] i_waddr
);

  localparam int DEPTH = 1 << NUM_GHR_BITS;

  logic [1:0] r_ctr [DEPTH];

  // Counter array: every entry starts weakly not-taken, updates saturate
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) r_ctr[i] <= PHT_RESET;
    end else if (i_we) begin
      r_ctr[i_waddr] <= sat_update(r_ctr[i_waddr], i_inc);
    end
  end

  // Read returns the stored value, so a same-cycle write is not forwarded
  assign o_rdata = r_ctr[i_raddr];

endmodule
`default_nettype wire

// File: rtl/ucsbece154b_gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154b_gshare_predictor
// Brief    : Fetch-side predictor: direct-mapped BTB, gshare PHT and a
//            speculative global history register. Lookups are combinational
//            from pc_i; all state updates occur on the rising clock edge.
//            Optional event counters are built when UCSBECE154B_PRED_STATS_EN
//            is defined; otherwise the stat outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ucsbece154b_gshare_predictor
  import ucsbece154b_pred_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 4
) (
  input  logic                               clk,
  input  logic                               reset_i,
  input  logic [31:0]                        pc_i,
  output logic [31:0]                        BTBtarget_o,
  output logic                               BranchTaken_o,
  output logic [NUM_GHR_BITS-1:0]            PHTreadaddress_o,
  input  logic [6:0]                         op_i,
  input  logic                               BTB_we,
  input  logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_i,
  input  logic [31:0]                        BTBwritedata_i,
  input  logic                               PHTwe_i,
  input  logic                               PHTincrement_i,
  input  logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_i,
  input  logic                               GHRwe_i,
  input  logic                               GHRreset_i,
  output logic [31:0]                        stat_pht_upd_o,
  output logic [31:0]                        stat_mispred_o,
  output logic [31:0]                        stat_btb_wr_o
);

  localparam int IDX = $clog2(NUM_BTB_ENTRIES);

  btb_entry_t              r_btb [NUM_BTB_ENTRIES];
  logic [NUM_GHR_BITS-1:0] r_ghr;

  logic [IDX-1:0]          w_btb_idx;
  btb_entry_t              w_btb_rd;
  logic [1:0]              w_pht_ctr;
  logic                    w_unused;

  // The opcode is only kept for port compatibility; pc_i is partly used
  assign w_unused = ^{op_i, pc_i};

  assign w_btb_idx        = pc_i[IDX+1:2];
  assign w_btb_rd         = r_btb[w_btb_idx];
  assign PHTreadaddress_o = pc_i[NUM_GHR_BITS+1:2] ^ r_ghr;
  assign BranchTaken_o    = w_btb_rd.valid & (w_btb_rd.jump | w_pht_ctr[1]);
  assign BTBtarget_o      = w_btb_rd.valid ? w_btb_rd.target : 32'h0;

  ucsbece154b_pht #(
    .NUM_GHR_BITS (NUM_GHR_BITS)
  ) u_pht (
    .clk     (clk),
    .reset_i (reset_i),
    .i_raddr (PHTreadaddress_o),
    .o_rdata (w_pht_ctr),
    .i_we    (PHTwe_i),
    .i_inc   (PHTincrement_i),
    .i_waddr (PHTwriteaddress_i)
  );

  // BTB fill: a write that also updates the PHT is a conditional branch
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) r_btb[i] <= '0;
    end else if (BTB_we) begin
      r_btb[BTBwriteaddress_i] <= '{valid: 1'b1, jump: ~PHTwe_i, target: BTBwritedata_i};
    end
  end

  // Speculative history: mispredict clears, a fetched branch shifts in the prediction
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_ghr <= '0;
    end else if (GHRreset_i) begin
      r_ghr <= '0;
    end else if (GHRwe_i) begin
      r_ghr <= {r_ghr[NUM_GHR_BITS-2:0], BranchTaken_o};
    end
  end

`ifdef UCSBECE154B_PRED_STATS_EN
  logic [31:0] r_stat_pht_upd;
  logic [31:0] r_stat_mispred;
  logic [31:0] r_stat_btb_wr;

  // Event counters, each saturating at all-ones
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_stat_pht_upd <= '0;
      r_stat_mispred <= '0;
      r_stat_btb_wr  <= '0;
    end else begin
      if (PHTwe_i && (r_stat_pht_upd != 32'hFFFF_FFFF)) r_stat_pht_upd <= r_stat_pht_upd + 32'd1;
      if (GHRreset_i && (r_stat_mispred != 32'hFFFF_FFFF)) r_stat_mispred <= r_stat_mispred + 32'd1;
      if (BTB_we && (r_stat_btb_wr != 32'hFFFF_FFFF)) r_stat_btb_wr <= r_stat_btb_wr + 32'd1;
    end
  end

  assign stat_pht_upd_o = r_stat_pht_upd;
  assign stat_mispred_o = r_stat_mispred;
  assign stat_btb_wr_o  = r_stat_btb_wr;
`else
  assign stat_pht_upd_o = 32'h0;
  assign stat_mispred_o = 32'h0;
  assign stat_btb_wr_o  = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucsbece154b_gshare_predictor
// Brief    : Self-checking bench for the gshare predictor. A behavioural
//            model tracks BTB/PHT/GHR contents as plain arrays and integers;
//            outputs are compared on every falling edge, and directed steps
//            pin hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucsbece154b_gshare_predictor;

  localparam int NB = 32;
  localparam int NG = 4;
  localparam int NP = 16;
`ifdef UCSBECE154B_PRED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i;
  logic [31:0]   pc_i;
  logic [31:0]   BTBtarget_o;
  logic          BranchTaken_o;
  logic [NG-1:0] PHTreadaddress_o;
  logic [6:0]    op_i;
  logic          BTB_we;
  logic [4:0]    BTBwriteaddress_i;
  logic [31:0]   BTBwritedata_i;
  logic          PHTwe_i;
  logic          PHTincrement_i;
  logic [NG-1:0] PHTwriteaddress_i;
  logic          GHRwe_i;
  logic          GHRreset_i;
  logic [31:0]   stat_pht_upd_o;
  logic [31:0]   stat_mispred_o;
  logic [31:0]   stat_btb_wr_o;

  int total = 0;
  int bad   = 0;

  ucsbece154b_gshare_predictor #(
    .NUM_BTB_ENTRIES (NB),
    .NUM_GHR_BITS    (NG)
  ) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .pc_i              (pc_i),
    .BTBtarget_o       (BTBtarget_o),
    .BranchTaken_o     (BranchTaken_o),
    .PHTreadaddress_o  (PHTreadaddress_o),
    .op_i              (op_i),
    .BTB_we            (BTB_we),
    .BTBwriteaddress_i (BTBwriteaddress_i),
    .BTBwritedata_i    (BTBwritedata_i),
    .PHTwe_i           (PHTwe_i),
    .PHTincrement_i    (PHTincrement_i),
    .PHTwriteaddress_i (PHTwriteaddress_i),
    .GHRwe_i           (GHRwe_i),
    .GHRreset_i        (GHRreset_i),
    .stat_pht_upd_o    (stat_pht_upd_o),
    .stat_mispred_o    (stat_mispred_o),
    .stat_btb_wr_o     (stat_btb_wr_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_valid [NB];
  bit          m_jump  [NB];
  logic [31:0] m_tgt   [NB];
  int          m_pht   [NP];
  int          m_ghr;
  longint      m_st_pht, m_st_mis, m_st_btb;

  function automatic int m_bidx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(NB));
  endfunction

  function automatic int m_pidx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(NP)) ^ m_ghr;
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    int b;
    b = m_bidx(pc);
    return m_valid[b] && (m_jump[b] || (m_pht[m_pidx(pc)] >= 2));
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    int b;
    b = m_bidx(pc);
    return m_valid[b] ? m_tgt[b] : 32'h0;
  endfunction

  always @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NB; i++) m_valid[i] <= 1'b0;
      for (int i = 0; i < NP; i++) m_pht[i] <= 1;
      m_ghr    <= 0;
      m_st_pht <= 0;
      m_st_mis <= 0;
      m_st_btb <= 0;
    end else begin
      if (GHRreset_i) m_ghr <= 0;
      else if (GHRwe_i) m_ghr <= (m_ghr * 2 + (m_taken(pc_i) ? 1 : 0)) % NP;
      if (PHTwe_i) begin
        if (PHTincrement_i)
          m_pht[int'(PHTwriteaddress_i)] <= (m_pht[int'(PHTwriteaddress_i)] == 3) ? 3 : m_pht[int'(PHTwriteaddress_i)] + 1;
        else
          m_pht[int'(PHTwriteaddress_i)] <= (m_pht[int'(PHTwriteaddress_i)] == 0) ? 0 : m_pht[int'(PHTwriteaddress_i)] - 1;
      end
      if (BTB_we) begin
        m_valid[int'(BTBwriteaddress_i)] <= 1'b1;
        m_jump[int'(BTBwriteaddress_i)]  <= !PHTwe_i;
        m_tgt[int'(BTBwriteaddress_i)]   <= BTBwritedata_i;
      end
      if (PHTwe_i && m_st_pht < 64'hFFFF_FFFF) m_st_pht <= m_st_pht + 1;
      if (GHRreset_i && m_st_mis < 64'hFFFF_FFFF) m_st_mis <= m_st_mis + 1;
      if (BTB_we && m_st_btb < 64'hFFFF_FFFF) m_st_btb <= m_st_btb + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge: DUT outputs against the model
  always @(negedge clk) begin
    check("m_taken", 32'(BranchTaken_o), 32'(m_taken(pc_i)));
    check("m_target", BTBtarget_o, m_target(pc_i));
    check("m_phtaddr", 32'(PHTreadaddress_o), 32'(m_pidx(pc_i)));
    check("m_stat_pht", stat_pht_upd_o, STATS ? m_st_pht[31:0] : 32'h0);
    check("m_stat_mis", stat_mispred_o, STATS ? m_st_mis[31:0] : 32'h0);
    check("m_stat_btb", stat_btb_wr_o, STATS ? m_st_btb[31:0] : 32'h0);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    BTB_we     = 1'b0;
    PHTwe_i    = 1'b0;
    GHRwe_i    = 1'b0;
    GHRreset_i = 1'b0;
  endtask

  initial begin
    reset_i           = 1'b0;
    pc_i              = 32'h100;
    op_i              = 7'h0;
    BTBwriteaddress_i = '0;
    BTBwritedata_i    = '0;
    PHTincrement_i    = 1'b0;
    PHTwriteaddress_i = '0;
    clr();
    repeat (2) step();

    // Reset state
    check("rst_taken", 32'(BranchTaken_o), 32'h0);
    check("rst_target", BTBtarget_o, 32'h0);
    check("rst_phtaddr", 32'(PHTreadaddress_o), 32'h0);
    reset_i = 1'b1;
    step();

    // Unconditional jump at BTB index 5
    BTB_we = 1'b1; BTBwriteaddress_i = 5'd5; BTBwritedata_i = 32'h200;
    step(); clr();
    pc_i = 32'h14; #1;
    check("jump_taken", 32'(BranchTaken_o), 32'h1);
    check("jump_target", BTBtarget_o, 32'h200);

    // Conditional branch at index 5, PHT[5] 01 -> 00
    BTB_we = 1'b1; PHTwe_i = 1'b1; PHTincrement_i = 1'b0;
    BTBwriteaddress_i = 5'd5; PHTwriteaddress_i = 4'd5; BTBwritedata_i = 32'h80;
    step(); clr(); #1;
    check("cond_nt_taken", 32'(BranchTaken_o), 32'h0);
    check("cond_target", BTBtarget_o, 32'h80);

    // Two increments: 00 -> 01 -> 10
    PHTwe_i = 1'b1; PHTincrement_i = 1'b1;
    repeat (2) step();
    clr(); #1;
    check("cond_t_taken", 32'(BranchTaken_o), 32'h1);

    // Saturation: four decrements reach 00, one increment gives 01
    PHTwe_i = 1'b1; PHTincrement_i = 1'b0;
    repeat (4) step();
    PHTincrement_i = 1'b1;
    step(); clr(); #1;
    check("wnt_taken", 32'(BranchTaken_o), 32'h0);
    // Five increments saturate at 11; one decrement stays taken, two do not
    PHTwe_i = 1'b1; PHTincrement_i = 1'b1;
    repeat (5) step();
    clr(); #1;
    check("st_taken", 32'(BranchTaken_o), 32'h1);
    PHTwe_i = 1'b1; PHTincrement_i = 1'b0;
    step(); clr(); #1;
    check("st_dec1_taken", 32'(BranchTaken_o), 32'h1);
    PHTwe_i = 1'b1;
    step(); clr(); #1;
    check("st_dec2_taken", 32'(BranchTaken_o), 32'h0);

    // GHR shifts in predictions 1,0,1 using a jump at index 7
    BTB_we = 1'b1; BTBwriteaddress_i = 5'd7; BTBwritedata_i = 32'h300;
    step(); clr();
    GHRwe_i = 1'b1;
    pc_i = 32'h1C;  step();
    pc_i = 32'h100; step();
    pc_i = 32'h1C;  step();
    GHRwe_i = 1'b0; pc_i = 32'h100; #1;
    check("ghr_0101", 32'(PHTreadaddress_o), 32'h5);
    GHRwe_i = 1'b1; GHRreset_i = 1'b1;
    step(); clr(); #1;
    check("ghr_clear", 32'(PHTreadaddress_o), 32'h0);

    // Statistics after a fresh reset
    reset_i = 1'b0; step(); reset_i = 1'b1;
    PHTwe_i = 1'b1; PHTincrement_i = 1'b1; PHTwriteaddress_i = 4'd2;
    repeat (3) step();
    PHTwe_i = 1'b0; GHRreset_i = 1'b1;
    repeat (2) step();
    clr(); #1;
    check("stat_pht", stat_pht_upd_o, STATS ? 32'd3 : 32'd0);
    check("stat_mis", stat_mispred_o, STATS ? 32'd2 : 32'd0);
    check("stat_btb", stat_btb_wr_o, 32'd0);
    reset_i = 1'b0; #1;
    check("stat_rst_pht", stat_pht_upd_o, 32'd0);
    check("stat_rst_mis", stat_mispred_o, 32'd0);
    check("stat_rst_btb", stat_btb_wr_o, 32'd0);
    step(); reset_i = 1'b1;

    // Mixed traffic, checked by the model on every cycle
    for (int n = 0; n < 300; n++) begin
      pc_i              = 32'($urandom_range(0, 255)) << 2;
      BTB_we            = 1'($urandom);
      BTBwriteaddress_i = 5'($urandom);
      BTBwritedata_i    = $urandom;
      PHTwe_i           = 1'($urandom);
      PHTincrement_i    = 1'($urandom);
      PHTwriteaddress_i = 4'($urandom);
      GHRwe_i           = 1'($urandom);
      GHRreset_i        = ($urandom_range(0, 7) == 0);
      step();
    end
    clr();
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
